// File: rtl/zeroasic_mae_pkg.sv
// Shared widths, accumulator word type and product sign-extension for the MAE core.
package zeroasic_mae_pkg;

  localparam int unsigned A_W    = 18;
  localparam int unsigned B_W    = 18;
  localparam int unsigned PROD_W = 36;
  localparam int unsigned P_W    = 40;

  typedef logic [P_W-1:0] acc_t;

  // Widen a signed product to the accumulator width.
  function automatic acc_t sext_prod(input logic [PROD_W-1:0] p);
    return {{(P_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/zeroasic_mae_core_if.sv
// Operand, control and result bundle of the MAE core.
interface zeroasic_mae_core_if;
  import zeroasic_mae_pkg::*;

  logic signed [A_W-1:0] A;
  logic                  A_EN;
  logic                  A_SRST_N;
  logic                  A_BYPASS;
  logic signed [B_W-1:0] B;
  logic                  B_EN;
  logic                  B_SRST_N;
  logic                  B_BYPASS;
  logic                  P_EN;
  logic                  P_SRST_N;
  logic                  P_BYPASS;
  logic [P_W-1:0]        P;

  modport slave (
    input  A, A_EN, A_SRST_N, A_BYPASS,
    input  B, B_EN, B_SRST_N, B_BYPASS,
    input  P_EN, P_SRST_N, P_BYPASS,
    output P
  );

  modport master (
    output A, A_EN, A_SRST_N, A_BYPASS,
    output B, B_EN, B_SRST_N, B_BYPASS,
    output P_EN, P_SRST_N, P_BYPASS,
    input  P
  );

endinterface

// File: rtl/zeroasic_mae_reg.sv
// Pipeline register with enable, sync clear, async clear and a static-present / runtime-bypass output mux.
module zeroasic_mae_reg #(
  parameter int unsigned W       = 18,
  parameter int unsigned PRESENT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  input  logic         i_en,
  input  logic         i_srst_n,
  input  logic         i_bypass,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Keeps clocking even when bypassed at runtime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (!i_srst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = ((PRESENT != 0) && !i_bypass) ? r_q : i_d;

endmodule

// File: rtl/zeroasic_mae_core.sv
// 18x18 signed multiplier with optional A/B/P staging and an optional 40-bit accumulating post-adder.
module zeroasic_mae_core
  import zeroasic_mae_pkg::*;
#(
  parameter int unsigned BYPASS_A          = 0,
  parameter int unsigned BYPASS_B          = 0,
  parameter int unsigned BYPASS_P          = 0,
  parameter int unsigned POST_ADDER_STATIC = 0
) (
  input  logic               CLK,
  input  logic               C_ARST_N,
  zeroasic_mae_core_if.slave mae
);

  logic signed [A_W-1:0]    w_a_q;
  logic signed [B_W-1:0]    w_b_q;
  logic signed [PROD_W-1:0] w_prod;
  acc_t                     w_prod_x;
  acc_t                     w_p_mult;
  acc_t                     w_acc_sum;
  acc_t                     w_p_macc;
  acc_t                     r_acc;

  zeroasic_mae_reg #(.W(A_W), .PRESENT(BYPASS_A)) u_reg_a (
    .clk      (CLK),
    .rst_n    (C_ARST_N),
    .i_d      (mae.A),
    .i_en     (mae.A_EN),
    .i_srst_n (mae.A_SRST_N),
    .i_bypass (mae.A_BYPASS),
    .o_q      (w_a_q)
  );

  zeroasic_mae_reg #(.W(B_W), .PRESENT(BYPASS_B)) u_reg_b (
    .clk      (CLK),
    .rst_n    (C_ARST_N),
    .i_d      (mae.B),
    .i_en     (mae.B_EN),
    .i_srst_n (mae.B_SRST_N),
    .i_bypass (mae.B_BYPASS),
    .o_q      (w_b_q)
  );

  assign w_prod   = PROD_W'(w_a_q) * PROD_W'(w_b_q);
  assign w_prod_x = sext_prod(w_prod);

  zeroasic_mae_reg #(.W(P_W), .PRESENT(BYPASS_P)) u_reg_p (
    .clk      (CLK),
    .rst_n    (C_ARST_N),
    .i_d      (w_prod_x),
    .i_en     (mae.P_EN),
    .i_srst_n (mae.P_SRST_N),
    .i_bypass (mae.P_BYPASS),
    .o_q      (w_p_mult)
  );

  // Accumulator wraps modulo 2^40; a sync clear drops the current product.
  always_ff @(posedge CLK or negedge C_ARST_N) begin
    if (!C_ARST_N) begin
      r_acc <= '0;
    end else if (!mae.P_SRST_N) begin
      r_acc <= '0;
    end else if (mae.P_EN) begin
      r_acc <= w_acc_sum;
    end
  end

  assign w_acc_sum = r_acc + w_prod_x;
  assign w_p_macc  = (BYPASS_P != 0) ? r_acc : w_acc_sum;
  assign mae.P     = (POST_ADDER_STATIC != 0) ? w_p_macc : w_p_mult;

endmodule
